// File: rtl/issue_fifo_pkg.sv
// Shared types and constants for the fetch -> issue instruction queue.
// Optional build macro: ISSUE_FIFO_BYPASS_EN (same-cycle write-to-read bypass).
package issue_fifo_pkg;

  localparam int FETCH_WIDTH = 2;
  localparam int ISSUE_WIDTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Number of valid fetch slots this cycle (0..2).
  function automatic logic [1:0] slot_count(input logic slot0, input logic slot1);
    return {1'b0, slot0} + {1'b0, slot1};
  endfunction

endpackage

// File: rtl/issue_fifo_ptr.sv
// Pointer, occupancy and flag logic for issue_fifo.
// Optional build macro: ISSUE_FIFO_BYPASS_EN -- pops and empty flags also
// see the entries being written this cycle.
module issue_fifo_ptr
  import issue_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic          write_en0,
  input  logic          write_en1,
  input  logic          read_en_master,
  input  logic          read_en_slave,
  output logic [AW-1:0] head,
  output logic [AW-1:0] tail,
  output logic [AW:0]   count,
  output logic [1:0]    wr_num,
  output logic [1:0]    rd_num,
  output logic          fifo_empty,
  output logic          fifo_almost_empty,
  output logic          fifo_full
);

  logic [1:0] rd_req;
  logic [AW:0] avail;

  // Compaction, clamped pop count and flag decode.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    fifo_full = count > (AW + 1)'(DEPTH - 2);
    wr_num    = (flush || fifo_full) ? 2'd0 : slot_count(write_en0, write_en1);
    rd_req    = read_en_master ? (read_en_slave ? 2'd2 : 2'd1) : 2'd0;
`ifdef ISSUE_FIFO_BYPASS_EN
    avail     = count + (AW + 1)'(wr_num);
`else
    avail     = count;
`endif
    rd_num    = (avail < (AW + 1)'(rd_req)) ? avail[1:0] : rd_req;
    fifo_empty        = (avail == '0);
    fifo_almost_empty = (avail == (AW + 1)'(1));
  end

  // Pointer and occupancy update; flush beats any same-cycle read or write.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(rd_num);
      tail  <= tail + AW'(wr_num);
      count <= count + (AW + 1)'(wr_num) - (AW + 1)'(rd_num);
    end
  end

  // Report upstream protocol slips: popping more than is held, writing while full.
  always_ff @(posedge clk) begin
    if (resetn && !flush) begin
      assert ((AW + 1)'(rd_req) <= avail)
        else $warning("issue_fifo: over-pop clamped (req=%0d avail=%0d)", rd_req, avail);
      assert (!(fifo_full && (write_en0 || write_en1)))
        else $warning("issue_fifo: write dropped while full");
    end
  end

endmodule

// File: rtl/issue_fifo.sv
// Dual-write, dual-read instruction queue between fetch and decode/issue.
// Optional build macro: ISSUE_FIFO_BYPASS_EN -- while fewer than two entries
// are held, incoming writes appear on the read ports in the same cycle.
module issue_fifo
  import issue_fifo_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        write_en0,
  input  logic        write_en1,
  input  logic [31:0] write_pc0,
  input  logic [31:0] write_pc1,
  input  logic [31:0] write_inst0,
  input  logic [31:0] write_inst1,
  input  logic        read_en_master,
  input  logic        read_en_slave,
  output logic [31:0] master_pc,
  output logic [31:0] master_inst,
  output logic [31:0] slave_pc,
  output logic [31:0] slave_inst,
  output logic        fifo_empty,
  output logic        fifo_almost_empty,
  output logic        fifo_full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] head, tail, head_p1, tail_p1;
  logic [AW:0]   count;
  logic [1:0]    wr_num, rd_num;
  fetch_entry_t  mem [DEPTH];
  fetch_entry_t  wr_entry0, wr_entry1, master_e, slave_e;

  issue_fifo_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk               (clk),
    .resetn            (resetn),
    .flush             (flush),
    .write_en0         (write_en0),
    .write_en1         (write_en1),
    .read_en_master    (read_en_master),
    .read_en_slave     (read_en_slave),
    .head              (head),
    .tail              (tail),
    .count             (count),
    .wr_num            (wr_num),
    .rd_num            (rd_num),
    .fifo_empty        (fifo_empty),
    .fifo_almost_empty (fifo_almost_empty),
    .fifo_full         (fifo_full)
  );

  // Compact the fetch slots so the oldest valid slot always lands at tail.
  always_comb begin
    wr_entry0 = write_en0 ? fetch_entry_t'{write_pc0, write_inst0}
                          : fetch_entry_t'{write_pc1, write_inst1};
    wr_entry1 = fetch_entry_t'{write_pc1, write_inst1};
    head_p1   = head + AW'(1);
    tail_p1   = tail + AW'(1);
  end

  // Entry storage; entries popped by bypass in the same cycle are written but
  // immediately skipped by head, which is equivalent to never enqueuing them.
  // NOTE: storage has no reset; count gates every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (wr_num != 2'd0) mem[tail]    <= wr_entry0;
    if (wr_num == 2'd2) mem[tail_p1] <= wr_entry1;
  end

  // Read mux at head / head+1, zeroed where no valid entry exists.
  always_comb begin
    master_e = '0;
    slave_e  = '0;
    if (count != '0)                 master_e = mem[head];
    if (count >= (AW + 1)'(2))       slave_e  = mem[head_p1];
`ifdef ISSUE_FIFO_BYPASS_EN
    if (count == '0) begin
      if (wr_num != 2'd0)            master_e = wr_entry0;
      if (wr_num == 2'd2)            slave_e  = wr_entry1;
    end else if (count == (AW + 1)'(1)) begin
      if (wr_num != 2'd0)            slave_e  = wr_entry0;
    end
`endif
  end

  assign master_pc   = master_e.pc;
  assign master_inst = master_e.inst;
  assign slave_pc    = slave_e.pc;
  assign slave_inst  = slave_e.inst;

endmodule

// File: tb/tb_issue_fifo.sv
// Directed self-checking bench for issue_fifo (DEPTH = 16).
// Checks the bypass behaviour when built with ISSUE_FIFO_BYPASS_EN.
module tb_issue_fifo;
  import issue_fifo_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        resetn, flush, write_en0, write_en1, read_en_master, read_en_slave;
  logic [31:0] write_pc0, write_pc1, write_inst0, write_inst1;
  logic [31:0] master_pc, master_inst, slave_pc, slave_inst;
  logic        fifo_empty, fifo_almost_empty, fifo_full;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  issue_fifo #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .flush             (flush),
    .write_en0         (write_en0),
    .write_en1         (write_en1),
    .write_pc0         (write_pc0),
    .write_pc1         (write_pc1),
    .write_inst0       (write_inst0),
    .write_inst1       (write_inst1),
    .read_en_master    (read_en_master),
    .read_en_slave     (read_en_slave),
    .master_pc         (master_pc),
    .master_inst       (master_inst),
    .slave_pc          (slave_pc),
    .slave_inst        (slave_inst),
    .fifo_empty        (fifo_empty),
    .fifo_almost_empty (fifo_almost_empty),
    .fifo_full         (fifo_full)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return ~pc ^ 32'h0F0F_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
      else begin
        tests_failed++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic drive(input logic we0, input logic we1, input logic [31:0] pc0,
                       input logic [31:0] pc1, input logic rm, input logic rs, input logic fl);
    write_en0      = we0;
    write_en1      = we1;
    write_pc0      = pc0;
    write_pc1      = pc1;
    write_inst0    = inst_of(pc0);
    write_inst1    = inst_of(pc1);
    read_en_master = rm;
    read_en_slave  = rs;
    flush          = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock with the given inputs, then return inputs to idle for checking.
  task automatic cyc(input logic we0, input logic we1, input logic [31:0] pc0,
                     input logic [31:0] pc1, input logic rm, input logic rs, input logic fl);
    drive(we0, we1, pc0, pc1, rm, rs, fl);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check("rst_empty",  32'(fifo_empty), 32'd1);
    check("rst_almost", 32'(fifo_almost_empty), 32'd0);
    check("rst_full",   32'(fifo_full), 32'd0);
    check("rst_minst",  master_inst, 32'h0);
    check("rst_spc",    slave_pc, 32'h0);
    resetn = 1'b1;
    tick();
    check("idle_empty", 32'(fifo_empty), 32'd1);

    // Dual write then dual read
    cyc(1'b1, 1'b1, 32'h100, 32'h104, 1'b0, 1'b0, 1'b0);
    check("dw_mpc",    master_pc, 32'h100);
    check("dw_minst",  master_inst, inst_of(32'h100));
    check("dw_spc",    slave_pc, 32'h104);
    check("dw_sinst",  slave_inst, inst_of(32'h104));
    check("dw_empty",  32'(fifo_empty), 32'd0);
    check("dw_almost", 32'(fifo_almost_empty), 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    check("dr_empty",  32'(fifo_empty), 32'd1);
    check("dr_mpc",    master_pc, 32'h0);

    // Three entries, pop master only while slot1-only write arrives
    cyc(1'b1, 1'b1, 32'h110, 32'h114, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 32'h118, 32'h0, 1'b0, 1'b0, 1'b0);
    check("c3_count",  32'(dut.u_ptr.count), 32'd3);
    cyc(1'b0, 1'b1, 32'h0, 32'h200, 1'b1, 1'b0, 1'b0);
    check("s1_count",  32'(dut.u_ptr.count), 32'd3);
    check("s1_mpc",    master_pc, 32'h114);
    check("s1_spc",    slave_pc, 32'h118);
    check("s1_sinst",  slave_inst, inst_of(32'h118));
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    check("s1_tail_mpc",   master_pc, 32'h200);
    check("s1_tail_minst", master_inst, inst_of(32'h200));
    check("s1_almost",     32'(fifo_almost_empty), 32'd1);
    check("op_pre_sinst",  slave_inst, 32'h0);
    check("op_pre_spc",    slave_pc, 32'h0);

    // Over-pop with one entry held: clamped to one
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    check("op_count",  32'(dut.u_ptr.count), 32'd0);
    check("op_empty",  32'(fifo_empty), 32'd1);
    check("op_almost", 32'(fifo_almost_empty), 32'd0);

    // Slave pop without master is ignored
    cyc(1'b1, 1'b1, 32'h120, 32'h124, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    check("so_count",  32'(dut.u_ptr.count), 32'd2);
    check("so_mpc",    master_pc, 32'h120);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    check("so_empty",  32'(fifo_empty), 32'd1);

    // Fill to full from a non-zero pointer so the drain crosses the wrap
    cyc(1'b1, 1'b0, 32'h1000, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) begin
      check("fill_full_low", 32'(fifo_full), 32'd0);
      cyc(1'b1, 1'b1, 32'h1004 + 32'(8 * k), 32'h1008 + 32'(8 * k), 1'b0, 1'b0, 1'b0);
    end
    check("fill_full",  32'(fifo_full), 32'd1);
    check("fill_count", 32'(dut.u_ptr.count), 32'd15);
    cyc(1'b1, 1'b1, 32'hDEAD_0000, 32'hDEAD_0004, 1'b0, 1'b0, 1'b0);
    check("drop_count", 32'(dut.u_ptr.count), 32'd15);
    check("drop_full",  32'(fifo_full), 32'd1);
    for (int j = 0; j < 7; j++) begin
      check("drain_mpc", master_pc, 32'h1000 + 32'(8 * j));
      check("drain_spc", slave_pc, 32'h1004 + 32'(8 * j));
      cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    end
    check("drain_last_mpc", master_pc, 32'h1038);
    check("drain_almost",   32'(fifo_almost_empty), 32'd1);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("drain_empty",    32'(fifo_empty), 32'd1);

    // Flush beats a same-cycle dual write and dual pop
    cyc(1'b1, 1'b1, 32'h2000, 32'h2004, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 32'h2008, 32'h200C, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 32'h2010, 32'h0, 1'b0, 1'b0, 1'b0);
    check("fl_pre_count", 32'(dut.u_ptr.count), 32'd5);
    cyc(1'b1, 1'b1, 32'h3000, 32'h3004, 1'b1, 1'b1, 1'b1);
    check("fl_count", 32'(dut.u_ptr.count), 32'd0);
    check("fl_empty", 32'(fifo_empty), 32'd1);
    check("fl_mpc",   master_pc, 32'h0);
    cyc(1'b1, 1'b0, 32'h4000, 32'h0, 1'b0, 1'b0, 1'b0);
    check("fl_post_mpc",    master_pc, 32'h4000);
    check("fl_post_almost", 32'(fifo_almost_empty), 32'd1);
    check("fl_post_spc",    slave_pc, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-operation, away from any clock edge
    cyc(1'b1, 1'b1, 32'h5000, 32'h5004, 1'b0, 1'b0, 1'b0);
    check("ar_pre_count", 32'(dut.u_ptr.count), 32'd2);
    #2 resetn = 1'b0;
    #1;
    check("ar_empty", 32'(fifo_empty), 32'd1);
    check("ar_mpc",   master_pc, 32'h0);
    check("ar_count", 32'(dut.u_ptr.count), 32'd0);
    #1 resetn = 1'b1;
    tick();

    // Write into an empty queue: same-cycle visibility depends on the build
    drive(1'b1, 1'b1, 32'h300, 32'h304, 1'b0, 1'b0, 1'b0);
    #1;
`ifdef ISSUE_FIFO_BYPASS_EN
    check("bp_mpc",   master_pc, 32'h300);
    check("bp_spc",   slave_pc, 32'h304);
    check("bp_empty", 32'(fifo_empty), 32'd0);
`else
    check("nb_mpc",   master_pc, 32'h0);
    check("nb_empty", 32'(fifo_empty), 32'd1);
`endif
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("lat_mpc", master_pc, 32'h300);
    check("lat_spc", slave_pc, 32'h304);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
